// File: rtl/scariv_csu_issue_ctrl.sv
// scariv_csu_issue_ctrl -- serializing issue controller in front of the CSU pipe.
// Dispatched CSR/system ops are buffered in order. One op is released at a time,
// only when it is the oldest uncommitted instruction, and the next waits for its done.
// Optional build macro: SCARIV_CSU_ISSUE_WATCHDOG_EN adds a lost-done watchdog;
// without it o_watchdog_err is tied low.
module scariv_csu_issue_ctrl #(
   parameter int ENTRY_SIZE = 4,
   parameter int CMT_ID_W   = 7,
   parameter int GRP_W      = 4,
   parameter int PAYLOAD_W  = 64
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_disp_valid,
   input  logic [CMT_ID_W-1:0]  i_disp_cmt_id,
   input  logic [GRP_W-1:0]     i_disp_grp_id,
   input  logic [PAYLOAD_W-1:0] i_disp_payload,
   output logic                 o_disp_ready,
   input  logic [CMT_ID_W-1:0]  i_cmt_head_cmt_id,
   input  logic [GRP_W-1:0]     i_cmt_head_grp_id,
   input  logic                 i_flush_valid,
   output logic                 o_issue_valid,
   output logic [CMT_ID_W-1:0]  o_issue_cmt_id,
   output logic [GRP_W-1:0]     o_issue_grp_id,
   output logic [PAYLOAD_W-1:0] o_issue_payload,
   input  logic                 i_done_valid,
   input  logic [CMT_ID_W-1:0]  i_done_cmt_id,
   input  logic [GRP_W-1:0]     i_done_grp_id,
   output logic                 o_busy,
   output logic                 o_watchdog_err
);

   localparam int PTR_W = $clog2(ENTRY_SIZE);
   localparam int CNT_W = $clog2(ENTRY_SIZE + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, DRAIN} state_t;

   state_t               r_state;
   state_t               w_state_nxt;

   logic [CMT_ID_W-1:0]  r_q_cmt_id  [ENTRY_SIZE];
   logic [GRP_W-1:0]     r_q_grp_id  [ENTRY_SIZE];
   logic [PAYLOAD_W-1:0] r_q_payload [ENTRY_SIZE];
   logic [PTR_W-1:0]     r_head;
   logic [PTR_W-1:0]     r_tail;
   logic [CNT_W-1:0]     r_count;

   logic [CMT_ID_W-1:0]  r_if_cmt_id;
   logic [GRP_W-1:0]     r_if_grp_id;
   logic [PAYLOAD_W-1:0] r_if_payload;

   logic                 w_push;
   logic                 w_pop;
   logic                 w_head_match;
   logic                 w_done_match;
   logic                 w_latch;

   assign o_disp_ready = !i_reset && (r_count < CNT_W'(ENTRY_SIZE)) && !i_flush_valid;
   assign w_push       = i_disp_valid && o_disp_ready;
   assign w_pop        = (r_state == ISSUE) && !i_flush_valid;
   assign w_head_match = (r_count != '0) &&
                         (r_q_cmt_id[r_head] == i_cmt_head_cmt_id) &&
                         (r_q_grp_id[r_head] == i_cmt_head_grp_id);
   assign w_done_match = i_done_valid &&
                         (i_done_cmt_id == r_if_cmt_id) &&
                         (i_done_grp_id == r_if_grp_id);

   // Queue storage: write the entry at the tail on an accepted dispatch.
   // NOTE: the data array has no reset; r_count alone says which entries are valid.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_q_cmt_id[r_tail]  <= i_disp_cmt_id;
         r_q_grp_id[r_tail]  <= i_disp_grp_id;
         r_q_payload[r_tail] <= i_disp_payload;
      end
   end

   // Queue pointers and occupancy; a flush empties the queue ahead of any pop or push.
   // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (i_flush_valid) begin
         r_head  <= r_tail;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + 1'b1;
         if (w_pop)  r_head <= r_head + 1'b1;
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   // FSM state register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   // FSM next state and issue strobe.
   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      w_state_nxt   = r_state;
      w_latch       = 1'b0;
      o_issue_valid = 1'b0;
      case (r_state)
         IDLE: begin
            if (!i_flush_valid && w_head_match) begin
               w_state_nxt = ISSUE;
               w_latch     = 1'b1;
            end
         end
         ISSUE: begin
            o_issue_valid = !i_flush_valid;
            w_state_nxt   = i_flush_valid ? IDLE : WAIT_DONE;
         end
         WAIT_DONE: begin
            if (w_done_match)       w_state_nxt = IDLE;
            else if (i_flush_valid) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            // The pipe cannot be killed; wait for the in-flight op to report done.
            if (w_done_match) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // In-flight registers: capture the queue head when it is selected for issue.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_if_cmt_id  <= '0;
         r_if_grp_id  <= '0;
         r_if_payload <= '0;
      end else if (w_latch) begin
         r_if_cmt_id  <= r_q_cmt_id[r_head];
         r_if_grp_id  <= r_q_grp_id[r_head];
         r_if_payload <= r_q_payload[r_head];
      end
   end

   assign o_issue_cmt_id  = r_if_cmt_id;
   assign o_issue_grp_id  = r_if_grp_id;
   assign o_issue_payload = r_if_payload;
   assign o_busy          = (r_count != '0) || (r_state != IDLE);

`ifdef SCARIV_CSU_ISSUE_WATCHDOG_EN
   logic [7:0] r_wd_cnt;
   logic       r_wd_err;

   // Watchdog: count cycles spent waiting for done; flag sticks once 255 is reached.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_wd_cnt <= '0;
         r_wd_err <= 1'b0;
      end else if (r_state == ISSUE && w_state_nxt == WAIT_DONE) begin
         r_wd_cnt <= '0;
      end else if ((r_state == WAIT_DONE || r_state == DRAIN) && r_wd_cnt != 8'hff) begin
         r_wd_cnt <= r_wd_cnt + 8'd1;
         if (r_wd_cnt == 8'hfe) r_wd_err <= 1'b1;
      end
   end

   assign o_watchdog_err = r_wd_err;
`else
   assign o_watchdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_scariv_csu_issue_ctrl.sv
// tb_scariv_csu_issue_ctrl -- scoreboard bench for scariv_csu_issue_ctrl.
// A transaction-level model (queue of ops plus "selected"/"outstanding" flags) predicts
// each cycle's outputs and the sequence of issued ops; a monitor compares at negedge.
module tb_scariv_csu_issue_ctrl;

   localparam int ENTRY_SIZE = 4;
   localparam int CMT_ID_W   = 7;
   localparam int GRP_W      = 4;
   localparam int PAYLOAD_W  = 64;

   logic                 i_clk = 1'b0;
   logic                 i_reset = 1'b1;
   logic                 i_disp_valid = 1'b0;
   logic [CMT_ID_W-1:0]  i_disp_cmt_id = '0;
   logic [GRP_W-1:0]     i_disp_grp_id = '0;
   logic [PAYLOAD_W-1:0] i_disp_payload = '0;
   logic                 o_disp_ready;
   logic [CMT_ID_W-1:0]  i_cmt_head_cmt_id = '0;
   logic [GRP_W-1:0]     i_cmt_head_grp_id = '0;
   logic                 i_flush_valid = 1'b0;
   logic                 o_issue_valid;
   logic [CMT_ID_W-1:0]  o_issue_cmt_id;
   logic [GRP_W-1:0]     o_issue_grp_id;
   logic [PAYLOAD_W-1:0] o_issue_payload;
   logic                 i_done_valid = 1'b0;
   logic [CMT_ID_W-1:0]  i_done_cmt_id = '0;
   logic [GRP_W-1:0]     i_done_grp_id = '0;
   logic                 o_busy;
   logic                 o_watchdog_err;

   scariv_csu_issue_ctrl #(
      .ENTRY_SIZE(ENTRY_SIZE), .CMT_ID_W(CMT_ID_W), .GRP_W(GRP_W), .PAYLOAD_W(PAYLOAD_W)
   ) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_disp_valid(i_disp_valid), .i_disp_cmt_id(i_disp_cmt_id),
      .i_disp_grp_id(i_disp_grp_id), .i_disp_payload(i_disp_payload),
      .o_disp_ready(o_disp_ready),
      .i_cmt_head_cmt_id(i_cmt_head_cmt_id), .i_cmt_head_grp_id(i_cmt_head_grp_id),
      .i_flush_valid(i_flush_valid),
      .o_issue_valid(o_issue_valid), .o_issue_cmt_id(o_issue_cmt_id),
      .o_issue_grp_id(o_issue_grp_id), .o_issue_payload(o_issue_payload),
      .i_done_valid(i_done_valid), .i_done_cmt_id(i_done_cmt_id), .i_done_grp_id(i_done_grp_id),
      .o_busy(o_busy), .o_watchdog_err(o_watchdog_err)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [CMT_ID_W-1:0]  cmt;
      logic [GRP_W-1:0]     grp;
      logic [PAYLOAD_W-1:0] pay;
   } ent_t;

   typedef struct {
      bit rst;
      bit ready;
      bit busy;
      bit iv;
      bit err;
   } exp_t;

   // Reference model state.
   ent_t m_q[$];
   ent_t m_sel;
   bit   m_launch;      // op selected; it goes out to the pipe next cycle
   bit   m_out;         // op in the pipe, done not yet seen
   int   m_age;
   bit   m_err;
   int   m_cycle;
   int   m_issue_cycle;

   // Pipe emulation knobs.
   bit   auto_done = 1'b1;
   int   done_dly  = 3;
   bit   spur      = 1'b0;

   // Scoreboard queues.
   exp_t exp_q[$];
   ent_t iss_q[$];

   int n_vec = 0;
   int n_err = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic ent_t mk(logic [CMT_ID_W-1:0] c, logic [GRP_W-1:0] g, logic [PAYLOAD_W-1:0] p);
      ent_t e;
      e.cmt = c;
      e.grp = g;
      e.pay = p;
      return e;
   endfunction

   function automatic logic [CMT_ID_W-1:0] head_c();
      if (m_q.size() > 0) return m_q[0].cmt;
      return 7'h7f;
   endfunction

   function automatic logic [GRP_W-1:0] head_g();
      if (m_q.size() > 0) return m_q[0].grp;
      return 4'h0;
   endfunction

   // One clock of stimulus: drive inputs, record expectations, advance the model.
   task automatic step(bit dv, ent_t d, logic [CMT_ID_W-1:0] hc, logic [GRP_W-1:0] hg, bit fl,
                       bit dnv, logic [CMT_ID_W-1:0] dnc, logic [GRP_W-1:0] dng);
      exp_t e;
      bit   rdy;
      bit   dm;
      i_disp_valid      = dv;
      i_disp_cmt_id     = d.cmt;
      i_disp_grp_id     = d.grp;
      i_disp_payload    = d.pay;
      i_cmt_head_cmt_id = hc;
      i_cmt_head_grp_id = hg;
      i_flush_valid     = fl;
      i_done_valid      = dnv;
      i_done_cmt_id     = dnc;
      i_done_grp_id     = dng;

      rdy     = (m_q.size() < ENTRY_SIZE) && !fl;
      e.rst   = 1'b0;
      e.ready = rdy;
      e.busy  = (m_q.size() != 0) || m_launch || m_out;
      e.iv    = m_launch && !fl;
      e.err   = m_err;
      exp_q.push_back(e);
      if (e.iv) iss_q.push_back(m_sel);

      dm = dnv && (dnc == m_sel.cmt) && (dng == m_sel.grp);
      if (m_launch) begin
         m_launch = 1'b0;
         if (!fl) begin
            m_out         = 1'b1;
            m_age         = 0;
            m_issue_cycle = m_cycle;
            void'(m_q.pop_front());
         end
      end else if (m_out) begin
`ifdef SCARIV_CSU_ISSUE_WATCHDOG_EN
         if (m_age < 255) begin
            m_age++;
            if (m_age == 255) m_err = 1'b1;
         end
`endif
         if (dm) m_out = 1'b0;
      end else if (!fl && m_q.size() > 0 && m_q[0].cmt == hc && m_q[0].grp == hg) begin
         m_launch = 1'b1;
         m_sel    = m_q[0];
      end

      if (fl) m_q.delete();
      else if (dv && rdy) m_q.push_back(d);
      m_cycle++;
      @(posedge i_clk);
      #1;
   endtask

   // Step with the done report produced by the emulated pipe.
   task automatic tick(bit dv, ent_t d, logic [CMT_ID_W-1:0] hc, logic [GRP_W-1:0] hg, bit fl);
      bit                  dnv = 1'b0;
      logic [CMT_ID_W-1:0] dnc = '0;
      logic [GRP_W-1:0]    dng = '0;
      if (auto_done && m_out && m_cycle >= m_issue_cycle + done_dly) begin
         dnv = 1'b1;
         dnc = m_sel.cmt;
         dng = m_sel.grp;
      end else if (spur) begin
         dnv = 1'b1;
         dnc = m_sel.cmt ^ 7'h01;
         dng = m_sel.grp;
      end
      step(dv, d, hc, hg, fl, dnv, dnc, dng);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) tick(1'b0, mk('0, '0, '0), head_c(), head_g(), 1'b0);
   endtask

   task automatic wait_launch(int budget);
      int k = 0;
      while (!m_launch && k < budget) begin
         tick(1'b0, mk('0, '0, '0), head_c(), head_g(), 1'b0);
         k++;
      end
      if (!m_launch) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_launch: no selection within %0d cycles", budget);
      end
   endtask

   task automatic do_reset(int n);
      exp_t e;
      i_reset       = 1'b1;
      i_disp_valid  = 1'b0;
      i_flush_valid = 1'b0;
      i_done_valid  = 1'b0;
      m_q.delete();
      iss_q.delete();
      m_launch = 1'b0;
      m_out    = 1'b0;
      m_age    = 0;
      m_err    = 1'b0;
      e.rst = 1'b1; e.ready = 1'b0; e.busy = 1'b0; e.iv = 1'b0; e.err = 1'b0;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(e);
         m_cycle++;
         @(posedge i_clk);
         #1;
      end
      i_reset = 1'b0;
   endtask

   // Monitor: pop expectations at the negedge and compare with the DUT.
   initial begin : monitor
      exp_t e;
      ent_t x;
      forever begin
         @(negedge i_clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("disp_ready",   64'(o_disp_ready),   64'(e.ready));
            check("busy",         64'(o_busy),         64'(e.busy));
            check("issue_valid",  64'(o_issue_valid),  64'(e.iv));
            check("watchdog_err", 64'(o_watchdog_err), 64'(e.err));
            if (e.rst) begin
               check("rst_issue_cmt_id",  64'(o_issue_cmt_id), 64'd0);
               check("rst_issue_grp_id",  64'(o_issue_grp_id), 64'd0);
               check("rst_issue_payload", o_issue_payload,     64'd0);
            end
         end
         if (o_issue_valid === 1'b1) begin
            if (iss_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_issue: got cmt %0h, expected no issue", o_issue_cmt_id);
            end else begin
               x = iss_q.pop_front();
               check("issue_cmt_id",  64'(o_issue_cmt_id), 64'(x.cmt));
               check("issue_grp_id",  64'(o_issue_grp_id), 64'(x.grp));
               check("issue_payload", o_issue_payload,     x.pay);
            end
         end
      end
   end

   initial begin : driver
      logic [GRP_W-1:0]    g;
      logic [CMT_ID_W-1:0] hc;
      logic [GRP_W-1:0]    hg;
      @(posedge i_clk);
      #1;
      do_reset(3);

      // Single op: cmt 5, group 0001, commit head already pointing at it.
      step(1'b1, mk(7'd5, 4'b0001, 64'hdead_beef_0000_0005), 7'd5, 4'b0001, 1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 8; i++) tick(1'b0, mk('0, '0, '0), 7'd5, 4'b0001, 1'b0);

      // Not oldest: cmt 9 waits while the head is 8, then issues once the head moves.
      step(1'b1, mk(7'd9, 4'b0010, 64'h0123_4567_89ab_cdef), 7'd8, 4'b0010, 1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 10; i++) tick(1'b0, mk('0, '0, '0), 7'd8, 4'b0010, 1'b0);
      for (int i = 0; i < 8; i++)  tick(1'b0, mk('0, '0, '0), 7'd9, 4'b0010, 1'b0);

      // Full: four entries without a head match, a fifth is refused, then drain.
      for (int i = 0; i < 5; i++)
         tick(1'b1, mk(7'(20 + i), 4'b0100, 64'(100 + i)), 7'h7f, 4'h0, 1'b0);
      idle(30);

      // Flush one cycle after issue with two more queued; DRAIN ignores a wrong done.
      for (int i = 0; i < 3; i++)
         tick(1'b1, mk(7'(30 + i), 4'b1000, 64'(200 + i)), 7'h7f, 4'h0, 1'b0);
      wait_launch(10);
      auto_done = 1'b0;
      idle(1);
      tick(1'b0, mk('0, '0, '0), 7'h7f, 4'h0, 1'b1);
      step(1'b0, mk('0, '0, '0), 7'h7f, 4'h0, 1'b0, 1'b1, m_sel.cmt ^ 7'h01, m_sel.grp);
      tick(1'b1, mk(7'd40, 4'b0001, 64'h40), 7'd40, 4'b0001, 1'b0);
      for (int i = 0; i < 4; i++) tick(1'b0, mk('0, '0, '0), 7'd40, 4'b0001, 1'b0);
      step(1'b0, mk('0, '0, '0), 7'd40, 4'b0001, 1'b0, 1'b1, m_sel.cmt, m_sel.grp);
      auto_done = 1'b1;
      idle(10);

      // Flush during the ISSUE cycle together with a dispatch.
      tick(1'b1, mk(7'd50, 4'b0010, 64'h50), 7'd50, 4'b0010, 1'b0);
      wait_launch(10);
      tick(1'b1, mk(7'd51, 4'b0010, 64'h51), 7'd50, 4'b0010, 1'b1);
      idle(5);

      // Lost done report: wait long enough for the watchdog, then reset mid-operation.
      auto_done = 1'b0;
      tick(1'b1, mk(7'd60, 4'b0100, 64'h60), 7'd60, 4'b0100, 1'b0);
      wait_launch(10);
      idle(300);
      tick(1'b1, mk(7'd61, 4'b0100, 64'h61), 7'h7f, 4'h0, 1'b0);
      do_reset(2);
      auto_done = 1'b1;
      idle(3);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         if (m_launch) done_dly = int'($urandom_range(3, 6));
         spur = ($urandom_range(0, 19) == 0);
         g    = 4'b0001 << $urandom_range(0, 3);
         if (m_q.size() > 0 && $urandom_range(0, 9) < 7) begin
            hc = m_q[0].cmt;
            hg = m_q[0].grp;
         end else begin
            hc = 7'(7'h70 + $urandom_range(0, 14));
            hg = g;
         end
         tick(($urandom_range(0, 1) == 1),
              mk(7'($urandom_range(0, 63)), g, {$urandom, $urandom}),
              hc, hg, ($urandom_range(0, 32) == 0));
      end
      spur = 1'b0;
      done_dly = 3;
      idle(20);

      @(negedge i_clk);
      #1;
      check("issues_all_seen", 64'(iss_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
